// File: rtl/jtag_dap_seq.sv
// ----------------------------------------------------------------------------
// jtag_dap_seq
//
// Turns one upstream ADIv5 DP/AP register access into the chain of JTAG
// pin-interface commands needed to carry it out:
//   - an IR scan (DPACC/APACC), skipped when the cached IR already matches,
//   - the DR transfer itself,
//   - for reads, an extra RDBUFF transfer to collect the posted result,
//   - optional WAIT retries of each transfer.
// A TAP reset request is also supported; it invalidates the IR cache.
//
// Build option:
//   JTAG_SEQ_RETRY_EN  defined   : a WAIT ack is retried up to MAX_RETRIES
//                                  times per transfer before being reported.
//                      undefined : the first WAIT is reported immediately.
//
// Ports:
//   clk, rst         clock, synchronous active-low reset
//   req, req_reset   start an access / a TAP reset (req_reset has priority)
//   apndp, rnw       AP(1)/DP(0) select, read(1)/write(0)
//   addr32, dwrite   register address bits [3:2], write data
//   busy, done       sequence in progress, one-cycle completion pulse
//   ack, dread       final JTAG ack, read data (updated by a good RDBUFF)
//   j_cmd .. j_go    command fields and launch strobe to the pin interface
//   j_idle, j_ack,   pin interface idle flag, ack and read data
//   j_dread
// ----------------------------------------------------------------------------
module jtag_dap_seq #(
   parameter int unsigned MAX_RETRIES = 15,
   parameter logic [3:0]  IR_DPACC    = 4'hA,
   parameter logic [3:0]  IR_APACC    = 4'hB
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        req_reset,
   input  logic        apndp,
   input  logic        rnw,
   input  logic [1:0]  addr32,
   input  logic [31:0] dwrite,
   output logic        busy,
   output logic        done,
   output logic [2:0]  ack,
   output logic [31:0] dread,
   output logic [1:0]  j_cmd,
   output logic [3:0]  j_ir,
   output logic [1:0]  j_addr32,
   output logic        j_rnw,
   output logic        j_apndp,
   output logic [31:0] j_dwrite,
   output logic        j_go,
   input  logic        j_idle,
   input  logic [2:0]  j_ack,
   input  logic [31:0] j_dread
);

   localparam logic [2:0] ACK_OK   = 3'b010;
   localparam logic [2:0] ACK_WAIT = 3'b001;
   localparam logic [1:0] CMD_IR   = 2'd0;
   localparam logic [1:0] CMD_TFR  = 2'd1;
   localparam logic [1:0] CMD_RST  = 2'd3;

   // Each command state X launches; X_W waits for the pin interface to finish.
   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_RST   = 4'd1,
      S_RST_W = 4'd2,
      S_IR    = 4'd3,
      S_IR_W  = 4'd4,
      S_TFR   = 4'd5,
      S_TFR_W = 4'd6,
      S_RDB   = 4'd7,
      S_RDB_W = 4'd8,
      S_DONE  = 4'd9
   } state_t;

   state_t      state_q, state_d;
   logic        ir_valid_q, ir_valid_d;
   logic [3:0]  ir_cur_q, ir_cur_d;
   logic        rdb_q, rdb_d;          // IR scan belongs to the RDBUFF phase
   logic        apndp_q, apndp_d;
   logic        rnw_q, rnw_d;
   logic [1:0]  addr_q, addr_d;
   logic [31:0] dwrite_q, dwrite_d;
   logic [2:0]  ack_q, ack_d;
   logic [31:0] dread_q, dread_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [1:0]  j_cmd_q, j_cmd_d;
   logic [3:0]  j_ir_q, j_ir_d;
   logic [1:0]  j_addr_q, j_addr_d;
   logic        j_rnw_q, j_rnw_d;
   logic        j_apndp_q, j_apndp_d;
   logic [31:0] j_dwrite_q, j_dwrite_d;
   logic        j_go_q, j_go_d;

   logic [3:0]  need_ir_s;
   logic        can_retry_s;

   assign need_ir_s = apndp ? IR_APACC : IR_DPACC;

`ifdef JTAG_SEQ_RETRY_EN
   localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRIES);

   logic [3:0] retry_q, retry_d;
   logic       xfer_start_s;
   logic       xfer_retry_s;

   // A fresh transfer is entered from anywhere except its own launch/wait pair.
   assign xfer_start_s = ((state_d == S_TFR) && (state_q != S_TFR) && (state_q != S_TFR_W)) ||
                         ((state_d == S_RDB) && (state_q != S_RDB) && (state_q != S_RDB_W));
   assign xfer_retry_s = ((state_q == S_TFR_W) && (state_d == S_TFR)) ||
                         ((state_q == S_RDB_W) && (state_d == S_RDB));
   assign can_retry_s  = (j_ack == ACK_WAIT) && (retry_q < RETRY_LIMIT);

   // Retry counter next state: cleared per transfer, bumped per re-launch.
   always_comb begin
      retry_d = retry_q;
      if (xfer_start_s) begin
         retry_d = 4'd0;
      end else if (xfer_retry_s) begin
         retry_d = retry_q + 4'd1;
      end else begin
         retry_d = retry_q;
      end
   end

   // Retry counter register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         retry_q <= 4'd0;
      end else begin
         retry_q <= retry_d;
      end
   end
`else
   assign can_retry_s = 1'b0;
`endif

   // Sequencer next-state and result bookkeeping.
   always_comb begin
      state_d    = state_q;
      ir_valid_d = ir_valid_q;
      ir_cur_d   = ir_cur_q;
      rdb_d      = rdb_q;
      apndp_d    = apndp_q;
      rnw_d      = rnw_q;
      addr_d     = addr_q;
      dwrite_d   = dwrite_q;
      ack_d      = ack_q;
      dread_d    = dread_q;
      case (state_q)
         S_IDLE: begin
            if (req_reset) begin
               state_d = S_RST;
            end else if (req) begin
               apndp_d  = apndp;
               rnw_d    = rnw;
               addr_d   = addr32;
               dwrite_d = dwrite;
               rdb_d    = 1'b0;
               if (ir_valid_q && (ir_cur_q == need_ir_s)) begin
                  state_d = S_TFR;
               end else begin
                  state_d = S_IR;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RST:   state_d = j_idle ? S_RST : S_RST_W;
         S_IR:    state_d = j_idle ? S_IR  : S_IR_W;
         S_TFR:   state_d = j_idle ? S_TFR : S_TFR_W;
         S_RDB:   state_d = j_idle ? S_RDB : S_RDB_W;
         S_RST_W: begin
            if (j_idle) begin
               ir_valid_d = 1'b0;
               ack_d      = ACK_OK;
               state_d    = S_DONE;
            end else begin
               state_d = S_RST_W;
            end
         end
         S_IR_W: begin
            if (j_idle) begin
               // The value just scanned is the one held on j_ir.
               ir_cur_d   = j_ir_q;
               ir_valid_d = 1'b1;
               state_d    = rdb_q ? S_RDB : S_TFR;
            end else begin
               state_d = S_IR_W;
            end
         end
         S_TFR_W: begin
            if (!j_idle) begin
               state_d = S_TFR_W;
            end else if (can_retry_s) begin
               state_d = S_TFR;
            end else if ((j_ack != ACK_OK) || !rnw_q) begin
               ack_d   = j_ack;
               state_d = S_DONE;
            end else begin
               // Posted read: the data arrives via DP RDBUFF.
               rdb_d = 1'b1;
               if (ir_valid_q && (ir_cur_q == IR_DPACC)) begin
                  state_d = S_RDB;
               end else begin
                  state_d = S_IR;
               end
            end
         end
         S_RDB_W: begin
            if (!j_idle) begin
               state_d = S_RDB_W;
            end else if (can_retry_s) begin
               state_d = S_RDB;
            end else begin
               ack_d = j_ack;
               if (j_ack == ACK_OK) begin
                  dread_d = j_dread;
               end else begin
                  dread_d = dread_q;
               end
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Registered outputs derived from the state being entered.
   always_comb begin
      busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d     = (state_d == S_DONE);
      j_cmd_d    = j_cmd_q;
      j_ir_d     = j_ir_q;
      j_addr_d   = j_addr_q;
      j_rnw_d    = j_rnw_q;
      j_apndp_d  = j_apndp_q;
      j_dwrite_d = j_dwrite_q;
      j_go_d     = 1'b0;
      case (state_d)
         S_RST: begin
            j_cmd_d = CMD_RST;
            j_go_d  = 1'b1;
         end
         S_IR: begin
            j_cmd_d = CMD_IR;
            j_ir_d  = (rdb_d || !apndp_d) ? IR_DPACC : IR_APACC;
            j_go_d  = 1'b1;
         end
         S_TFR: begin
            j_cmd_d    = CMD_TFR;
            j_apndp_d  = apndp_d;
            j_addr_d   = addr_d;
            j_rnw_d    = rnw_d;
            j_dwrite_d = dwrite_d;
            j_go_d     = 1'b1;
         end
         S_RDB: begin
            j_cmd_d    = CMD_TFR;
            j_apndp_d  = 1'b0;
            j_addr_d   = 2'b11;
            j_rnw_d    = 1'b1;
            j_dwrite_d = dwrite_d;
            j_go_d     = 1'b1;
         end
         default: j_go_d = 1'b0;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         ir_valid_q <= 1'b0;
         ir_cur_q   <= 4'd0;
         rdb_q      <= 1'b0;
         apndp_q    <= 1'b0;
         rnw_q      <= 1'b0;
         addr_q     <= 2'd0;
         dwrite_q   <= 32'd0;
         ack_q      <= 3'd0;
         dread_q    <= 32'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         j_cmd_q    <= 2'd0;
         j_ir_q     <= 4'd0;
         j_addr_q   <= 2'd0;
         j_rnw_q    <= 1'b0;
         j_apndp_q  <= 1'b0;
         j_dwrite_q <= 32'd0;
         j_go_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ir_valid_q <= ir_valid_d;
         ir_cur_q   <= ir_cur_d;
         rdb_q      <= rdb_d;
         apndp_q    <= apndp_d;
         rnw_q      <= rnw_d;
         addr_q     <= addr_d;
         dwrite_q   <= dwrite_d;
         ack_q      <= ack_d;
         dread_q    <= dread_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         j_cmd_q    <= j_cmd_d;
         j_ir_q     <= j_ir_d;
         j_addr_q   <= j_addr_d;
         j_rnw_q    <= j_rnw_d;
         j_apndp_q  <= j_apndp_d;
         j_dwrite_q <= j_dwrite_d;
         j_go_q     <= j_go_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign ack      = ack_q;
   assign dread    = dread_q;
   assign j_cmd    = j_cmd_q;
   assign j_ir     = j_ir_q;
   assign j_addr32 = j_addr_q;
   assign j_rnw    = j_rnw_q;
   assign j_apndp  = j_apndp_q;
   assign j_dwrite = j_dwrite_q;
   assign j_go     = j_go_q;

endmodule

// File: tb/tb_jtag_dap_seq.sv
// ----------------------------------------------------------------------------
// Testbench for jtag_dap_seq: a pin-interface responder with scripted acks,
// and a procedural reference model that lists the commands each access
// should produce and its final ack / read data.
// ----------------------------------------------------------------------------
module tb_jtag_dap_seq;

   localparam logic [2:0] OK    = 3'b010;
   localparam logic [2:0] WAIT  = 3'b001;
   localparam logic [2:0] FAULT = 3'b100;
`ifdef JTAG_SEQ_RETRY_EN
   localparam int MAXR = 15;
`else
   localparam int MAXR = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req = 1'b0;
   logic        req_reset = 1'b0;
   logic        apndp = 1'b0;
   logic        rnw = 1'b0;
   logic [1:0]  addr32 = 2'd0;
   logic [31:0] dwrite = 32'd0;
   logic        busy, done, j_rnw, j_apndp, j_go;
   logic [2:0]  ack;
   logic [31:0] dread, j_dwrite;
   logic [1:0]  j_cmd, j_addr32;
   logic [3:0]  j_ir;
   logic        j_idle = 1'b1;
   logic [2:0]  j_ack = 3'd0;
   logic [31:0] j_dread = 32'd0;

   jtag_dap_seq dut (
      .clk(clk), .rst(rst), .req(req), .req_reset(req_reset), .apndp(apndp),
      .rnw(rnw), .addr32(addr32), .dwrite(dwrite), .busy(busy), .done(done),
      .ack(ack), .dread(dread), .j_cmd(j_cmd), .j_ir(j_ir), .j_addr32(j_addr32),
      .j_rnw(j_rnw), .j_apndp(j_apndp), .j_dwrite(j_dwrite), .j_go(j_go),
      .j_idle(j_idle), .j_ack(j_ack), .j_dread(j_dread)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Normalised launch record: only the fields meaningful for the command.
   function automatic logic [41:0] lrec(input logic [1:0] cmd, input logic [3:0] ir,
                                        input logic ap, input logic [1:0] ad,
                                        input logic rn, input logic [31:0] wd);
      if (cmd == 2'd0)      return {cmd, ir, 36'd0};
      else if (cmd == 2'd1) return {cmd, 4'd0, ap, ad, rn, (rn ? 32'd0 : wd)};
      else                  return {cmd, 40'd0};
   endfunction

   // ---------------- pin interface responder ----------------
   logic [41:0] got_q[$];
   logic [2:0]  rsp_q[$];
   logic [31:0] rsp_data = 32'd0;
   int          lat_min = 0;
   int          lat_max = 2;
   int          pin_cnt = 0;
   logic [2:0]  pend_ack = 3'd0;
   logic [31:0] pend_data = 32'd0;

   always @(posedge clk) begin
      if (!rst) begin
         j_idle  <= 1'b1;
         pin_cnt <= 0;
      end else if (!j_idle) begin
         if (pin_cnt == 0) begin
            j_idle  <= 1'b1;
            j_ack   <= pend_ack;
            j_dread <= pend_data;
         end else begin
            pin_cnt <= pin_cnt - 1;
         end
      end else if (j_go) begin
         got_q.push_back(lrec(j_cmd, j_ir, j_apndp, j_addr32, j_rnw, j_dwrite));
         j_idle  <= 1'b0;
         j_ack   <= 3'($urandom);
         pin_cnt <= $urandom_range(lat_max, lat_min);
         if (j_cmd == 2'd1) begin
            pend_ack = OK;
            if (rsp_q.size() > 0) pend_ack = rsp_q.pop_front();
            pend_data = (j_rnw && !j_apndp && j_addr32 == 2'b11) ? rsp_data : $urandom;
         end else begin
            pend_ack  = 3'($urandom);
            pend_data = $urandom;
         end
      end
   end

   // ---------------- reference model ----------------
   logic        m_valid = 1'b0;
   logic [3:0]  m_cur = 4'd0;
   logic [31:0] m_dread = 32'd0;
   logic [2:0]  m_ack = 3'd0;
   logic [41:0] exp_q[$];
   logic [2:0]  scr[$];

   task automatic m_ir(input logic [3:0] need);
      if (!(m_valid && m_cur == need)) exp_q.push_back(lrec(2'd0, need, 1'b0, 2'd0, 1'b0, 32'd0));
      m_cur   = need;
      m_valid = 1'b1;
   endtask

   task automatic m_xfer(input logic ap, input logic [1:0] ad, input logic rn,
                         input logic [31:0] wd, output logic [2:0] res);
      int tries = 0;
      bit again;
      do begin
         exp_q.push_back(lrec(2'd1, 4'd0, ap, ad, rn, wd));
         res = OK;
         if (scr.size() > 0) res = scr.pop_front();
         again = (res == WAIT) && (tries < MAXR);
         tries++;
      end while (again);
   endtask

   task automatic model(input bit rs, input logic ap, input logic rn,
                        input logic [1:0] ad, input logic [31:0] wd);
      logic [2:0] r;
      if (rs) begin
         exp_q.push_back(lrec(2'd3, 4'd0, 1'b0, 2'd0, 1'b0, 32'd0));
         m_valid = 1'b0;
         m_ack   = OK;
      end else begin
         m_ir(ap ? 4'hB : 4'hA);
         m_xfer(ap, ad, rn, wd, r);
         if (r != OK || !rn) begin
            m_ack = r;
         end else begin
            m_ir(4'hA);
            m_xfer(1'b0, 2'b11, 1'b1, wd, r);
            m_ack = r;
            if (r == OK) m_dread = rsp_data;
         end
      end
   endtask

   // ---------------- one access, driven and checked ----------------
   task automatic run_txn(input bit rs, input logic ap, input logic rn,
                          input logic [1:0] ad, input logic [31:0] wd);
      int cyc = 0;
      rsp_q = scr;
      exp_q.delete();
      got_q.delete();
      model(rs, ap, rn, ad, wd);
      @(negedge clk);
      req       = rs ? 1'($urandom) : 1'b1;
      req_reset = rs;
      apndp = ap; rnw = rn; addr32 = ad; dwrite = wd;
      @(negedge clk);
      req = 1'b0; req_reset = 1'b0;
      check("busy_rise", busy, 1'b1);
      while (!done && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         // Requests while busy must be ignored; the fields are scrambled too.
         req    = ($urandom_range(3, 0) == 0);
         apndp  = 1'($urandom); rnw = 1'($urandom);
         addr32 = 2'($urandom); dwrite = $urandom;
      end
      req = 1'b0;
      check("done_seen", done, 1'b1);
      check("busy_at_done", busy, 1'b0);
      check("ack", ack, m_ack);
      check("dread", dread, m_dread);
      @(negedge clk);
      check("done_pulse", done, 1'b0);
      check("launch_count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (i < got_q.size()) check("launch", got_q[i], exp_q[i]);
   endtask

   task automatic push_waits(input int n);
      for (int i = 0; i < n; i++) scr.push_back(WAIT);
   endtask

   initial begin
      int cyc;
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ctl", {busy, done, ack, j_cmd, j_ir, j_addr32, j_rnw, j_apndp, j_go}, 0);
      check("rst_dread", dread, 0);
      rst = 1'b1;

      // 1: cold DP write -> IR + TFR
      scr.delete();
      run_txn(0, 1'b0, 1'b0, 2'd1, 32'h5000_0000);
      check("t1_go", got_q.size(), 2);
      // 2: repeat -> IR skipped
      scr.delete();
      run_txn(0, 1'b0, 1'b0, 2'd1, 32'h5000_0000);
      check("t2_go", got_q.size(), 1);
      // 3: AP read -> IR(B), TFR, IR(A), RDB
      scr.delete(); rsp_data = 32'h2477_0011;
      run_txn(0, 1'b1, 1'b1, 2'd3, 32'h0);
      check("t3_dread", dread, 32'h2477_0011);
      // 4: WAIT x3 then OK, and WAIT x20
      scr.delete(); push_waits(3);
      run_txn(0, 1'b0, 1'b0, 2'd2, 32'h1234_5678);
      scr.delete(); push_waits(20);
      run_txn(0, 1'b0, 1'b0, 2'd2, 32'h8765_4321);
      check("t4_ack", ack, WAIT);
      // 5: FAULT on AP read -> no RDB, dread held
      scr.delete(); scr.push_back(FAULT); rsp_data = 32'hDEAD_BEEF;
      run_txn(0, 1'b1, 1'b1, 2'd0, 32'h0);
      check("t5_dread", dread, 32'h2477_0011);
      // 6: TAP reset then DP read -> IR rescanned
      scr.delete();
      run_txn(1, 1'b0, 1'b0, 2'd0, 32'h0);
      scr.delete(); rsp_data = 32'hCAFE_0001;
      run_txn(0, 1'b0, 1'b1, 2'd1, 32'h0);

      // reset in the middle of a transfer
      lat_min = 20; lat_max = 30;
      got_q.delete();
      @(negedge clk);
      req = 1'b1; apndp = 1'b0; rnw = 1'b0; addr32 = 2'd2; dwrite = 32'hA5A5_5A5A;
      @(negedge clk);
      req = 1'b0;
      cyc = 0;
      while (got_q.size() < 1 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("mid_launch_seen", got_q.size(), 1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_ctl", {busy, done, ack, j_cmd, j_ir, j_addr32, j_rnw, j_apndp, j_go}, 0);
      check("mid_rst_dread", dread, 0);
      check("mid_rst_jdw", j_dwrite, 0);
      rst = 1'b1;
      m_valid = 1'b0; m_dread = 32'd0; m_ack = 3'd0;
      lat_min = 0; lat_max = 2;

      // randomized accesses
      for (int t = 0; t < 60; t++) begin
         bit rs;
         logic ap, rn;
         scr.delete();
         rs = ($urandom_range(9, 0) == 0);
         ap = 1'($urandom); rn = 1'($urandom);
         rsp_data = $urandom;
         push_waits(($urandom_range(7, 0) == 0) ? 17 : $urandom_range(3, 0));
         case ($urandom_range(9, 0))
            0:       scr.push_back(FAULT);
            1:       scr.push_back(3'b111);
            default: scr.push_back(OK);
         endcase
         push_waits($urandom_range(2, 0));
         if ($urandom_range(4, 0) == 0) scr.push_back(FAULT);
         run_txn(rs, ap, rn, 2'($urandom), $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
